coalescing_store_buffer: RTL and testbench

// - Parametrised successor to the 4-entry store buffer. Sits between the MEM stage and the data cache/memory port.
// - Circular FIFO, so drain order is strict program order; no age counters and no wrap-around hazard.
// - Byte-granular store coalescing into the youngest entry.
// - Per-byte merged store-to-load forwarding with full/partial hit reporting.
// - Flush/drain mode for fences.

---
 rtl/sb_pkg.sv | 36 +++
 rtl/sb_fwd_merge.sv | 64 ++++++
 rtl/coalescing_store_buffer.sv | 130 +++++++++++++
 tb/tb_coalescing_store_buffer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared definitions for the coalescing store buffer: default geometry,
// lane/offset width helpers and the word-address function.
package sb_pkg;

  localparam int unsigned SB_DEPTH  = 8;
  localparam int unsigned SB_ADDR_W = 32;
  localparam int unsigned SB_DATA_W = 32;
  localparam int unsigned SB_MAX_AW = 64;

  function automatic int unsigned be_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned word_off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  localparam int unsigned SB_BE_W      = be_w(SB_DATA_W);
  localparam int unsigned WORD_OFF_W   = word_off_w(SB_DATA_W);
  localparam int unsigned SB_WORD_W    = SB_ADDR_W - WORD_OFF_W;

  // Word address: byte address with the lane offset stripped.
  function automatic logic [SB_MAX_AW-1:0] word_addr(input logic [SB_MAX_AW-1:0] addr,
                                                     input int unsigned off_w);
    return addr >> off_w;
  endfunction

  // Field layout of one entry at the default geometry.
  typedef struct packed {
    logic                 vld;
    logic [SB_WORD_W-1:0] word;
    logic [SB_DATA_W-1:0] data;
    logic [SB_BE_W-1:0]   be;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_merge.sv
// Store-to-load forwarding: walks entries oldest to youngest starting at the
// head pointer so younger matching stores overwrite older lanes.
module sb_fwd_merge
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH,
  parameter int unsigned WA_W   = SB_WORD_W,
  parameter int unsigned DATA_W = SB_DATA_W,
  parameter int unsigned BE_W   = DATA_W / 8,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0]  head,
  input  logic              e_vld  [DEPTH],
  input  logic [WA_W-1:0]   e_addr [DEPTH],
  input  logic [DATA_W-1:0] e_data [DEPTH],
  input  logic [BE_W-1:0]   e_be   [DEPTH],
  input  logic              lookup_valid,
  input  logic [WA_W-1:0]   lookup_word,
  input  logic [BE_W-1:0]   lookup_be,
  output logic              lookup_hit,
  output logic              lookup_partial,
  output logic [DATA_W-1:0] lookup_data,
  output logic [BE_W-1:0]   lookup_be_out
);

  logic [DATA_W-1:0] merged;
  logic [BE_W-1:0]   covered;
  logic [PTR_W-1:0]  idx;
  logic [BE_W-1:0]   hit_be;

  // Youngest-wins per-lane merge across all matching valid entries.
  always_comb begin
    merged  = '0;
    covered = '0;
    idx     = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = head + PTR_W'(i);
      if (e_vld[idx] && (e_addr[idx] == lookup_word)) begin
        for (int l = 0; l < int'(BE_W); l++) begin
          if (e_be[idx][l]) begin
            merged[l*8 +: 8] = e_data[idx][l*8 +: 8];
            covered[l]       = 1'b1;
          end
        end
      end
    end
  end

  // Hit classification; an idle probe reports nothing.
  always_comb begin
    hit_be         = covered & lookup_be;
    lookup_hit     = 1'b0;
    lookup_partial = 1'b0;
    lookup_data    = '0;
    lookup_be_out  = '0;
    if (lookup_valid) begin
      lookup_be_out  = hit_be;
      lookup_data    = merged;
      lookup_hit     = (lookup_be != '0) && (hit_be == lookup_be);
      lookup_partial = (hit_be != '0) && (hit_be != lookup_be);
    end
  end

endmodule

// File: rtl/coalescing_store_buffer.sv
// Circular-FIFO store buffer between MEM and the data port. Stores coalesce
// byte-wise into the youngest entry (never the head), drain in program order,
// and forward merged data to loads.
module coalescing_store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH    = SB_DEPTH,
  parameter int unsigned ADDR_W   = SB_ADDR_W,
  parameter int unsigned DATA_W   = SB_DATA_W,
  parameter int unsigned COALESCE = 1,
  localparam int unsigned BE_W    = be_w(DATA_W),
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [BE_W-1:0]   st_be,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_addr,
  input  logic [BE_W-1:0]   lookup_be,
  output logic              lookup_hit,
  output logic              lookup_partial,
  output logic [DATA_W-1:0] lookup_data,
  output logic [BE_W-1:0]   lookup_be_out,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [BE_W-1:0]   mem_be,
  input  logic              flush,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned OFF_W = word_off_w(DATA_W);
  localparam int unsigned WA_W  = ADDR_W - OFF_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic              e_vld  [DEPTH];
  logic [WA_W-1:0]   e_addr [DEPTH];
  logic [DATA_W-1:0] e_data [DEPTH];
  logic [BE_W-1:0]   e_be   [DEPTH];

  logic [PTR_W-1:0]  head, tail, tail_m1;
  logic [WA_W-1:0]   st_word, lookup_word;
  logic [DATA_W-1:0] st_mask;
  logic              coalesce_hit, do_merge, do_alloc, pop;

  assign st_word     = WA_W'(word_addr(SB_MAX_AW'(st_addr), OFF_W));
  assign lookup_word = WA_W'(word_addr(SB_MAX_AW'(lookup_addr), OFF_W));
  assign tail_m1     = tail - PTR_W'(1);

  // Merge only when the youngest entry is not also the head, so a stalled
  // head presented on mem_* never changes underneath the memory port.
  assign coalesce_hit = (COALESCE != 0) && st_valid && (count >= CNT_W'(2)) &&
                        (e_addr[tail_m1] == st_word);
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign st_ready = !flush && (!full || coalesce_hit);
  assign do_merge = st_valid && st_ready && coalesce_hit;
  assign do_alloc = st_valid && st_ready && !coalesce_hit;
  assign pop      = mem_valid && mem_ready;

  assign mem_valid = !empty;
  assign mem_addr  = ADDR_W'(e_addr[head]) << OFF_W;
  assign mem_data  = e_data[head];
  assign mem_be    = e_be[head];

  // Expand byte enables to a bit mask so unwritten lanes of a new entry are 0.
  always_comb begin
    st_mask = '0;
    for (int l = 0; l < int'(BE_W); l++) st_mask[l*8 +: 8] = {8{st_be[l]}};
  end

  // Pointer, count and entry storage updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) e_vld[i] <= 1'b0;
    end else begin
      if (do_merge) begin
        for (int l = 0; l < int'(BE_W); l++) begin
          if (st_be[l]) begin
            e_data[tail_m1][l*8 +: 8] <= st_data[l*8 +: 8];
            e_be[tail_m1][l]          <= 1'b1;
          end
        end
      end else if (do_alloc) begin
        e_vld[tail]  <= 1'b1;
        e_addr[tail] <= st_word;
        e_data[tail] <= st_data & st_mask;
        e_be[tail]   <= st_be;
        tail         <= tail + PTR_W'(1);
      end
      if (pop) begin
        e_vld[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(do_alloc) - CNT_W'(pop);
    end
  end

  sb_fwd_merge #(
    .DEPTH (DEPTH),
    .WA_W  (WA_W),
    .DATA_W(DATA_W),
    .BE_W  (BE_W),
    .PTR_W (PTR_W)
  ) u_fwd (
    .head          (head),
    .e_vld         (e_vld),
    .e_addr        (e_addr),
    .e_data        (e_data),
    .e_be          (e_be),
    .lookup_valid  (lookup_valid),
    .lookup_word   (lookup_word),
    .lookup_be     (lookup_be),
    .lookup_hit    (lookup_hit),
    .lookup_partial(lookup_partial),
    .lookup_data   (lookup_data),
    .lookup_be_out (lookup_be_out)
  );

endmodule

// File: tb/tb_coalescing_store_buffer.sv
// Directed bench for coalescing_store_buffer at DEPTH=8, DATA_W=32.
module tb_coalescing_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        lookup_valid;
  logic [31:0] lookup_addr;
  logic [3:0]  lookup_be;
  logic        lookup_hit;
  logic        lookup_partial;
  logic [31:0] lookup_data;
  logic [3:0]  lookup_be_out;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        flush;
  logic        empty;
  logic        full;
  logic [3:0]  count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  coalescing_store_buffer #(.DEPTH(8), .ADDR_W(32), .DATA_W(32), .COALESCE(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .st_be         (st_be),
    .lookup_valid  (lookup_valid),
    .lookup_addr   (lookup_addr),
    .lookup_be     (lookup_be),
    .lookup_hit    (lookup_hit),
    .lookup_partial(lookup_partial),
    .lookup_data   (lookup_data),
    .lookup_be_out (lookup_be_out),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_be        (mem_be),
    .flush         (flush),
    .empty         (empty),
    .full          (full),
    .count         (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic probe(input logic [31:0] a, input logic [3:0] be);
    lookup_valid = 1'b1;
    lookup_addr  = a;
    lookup_be    = be;
    #1;
  endtask

  task automatic drain(input int n);
    mem_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    mem_ready = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    lookup_valid = 1'b0; lookup_addr = '0; lookup_be = '0;
    mem_ready = 1'b0; flush = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_full", 64'(full), 0);
    chk("rst_mem_valid", 64'(mem_valid), 0);
    chk("rst_st_ready", 64'(st_ready), 1);
    probe(32'h10, 4'hF);
    chk("rst_hit", 64'(lookup_hit), 0);
    chk("rst_partial", 64'(lookup_partial), 0);
    lookup_valid = 1'b0;

    // 1: in-order drain
    store(32'h10, 32'hA1, 4'hF);
    store(32'h20, 32'hA2, 4'hF);
    store(32'h30, 32'hA3, 4'hF);
    store(32'h40, 32'hA4, 4'hF);
    #1;
    chk("t1_count", 64'(count), 4);
    chk("t1_mem_addr0", 64'(mem_addr), 32'h10);
    chk("t1_mem_data0", 64'(mem_data), 32'hA1);
    mem_ready = 1'b1;
    #1;
    chk("t1_pop0", 64'(mem_addr), 32'h10);
    tick();
    chk("t1_pop1", 64'(mem_addr), 32'h20);
    tick();
    chk("t1_pop2", 64'(mem_addr), 32'h30);
    tick();
    chk("t1_pop3", 64'(mem_addr), 32'h40);
    tick();
    chk("t1_empty", 64'(empty), 1);
    chk("t1_mem_valid", 64'(mem_valid), 0);
    mem_ready = 1'b0;

    // 2: coalesce two halves of a word into the youngest entry
    store(32'h200, 32'h12345678, 4'hF);
    store(32'h100, 32'h0000AABB, 4'b0011);
    store(32'h102, 32'hCCDD0000, 4'b1100);
    #1;
    chk("t2_count", 64'(count), 2);
    probe(32'h100, 4'hF);
    chk("t2_hit", 64'(lookup_hit), 1);
    chk("t2_lk_data", 64'(lookup_data), 32'hCCDDAABB);
    lookup_valid = 1'b0;
    drain(1);
    chk("t2_mem_addr", 64'(mem_addr), 32'h100);
    chk("t2_mem_data", 64'(mem_data), 32'hCCDDAABB);
    chk("t2_mem_be", 64'(mem_be), 4'hF);
    drain(1);
    chk("t2_empty", 64'(empty), 1);

    // 3: full buffer, coalesce still allowed, stalled store waits for a pop
    for (int i = 0; i < 8; i++) store(32'h1000 + 32'(4 * i), 32'hA0000000 + 32'(i), 4'hF);
    #1;
    chk("t3_full", 64'(full), 1);
    st_valid = 1'b1; st_addr = 32'h2000; st_data = 32'h77; st_be = 4'hF;
    #1;
    chk("t3_nomatch_ready", 64'(st_ready), 0);
    st_addr = 32'h101C; st_data = 32'h000000EE; st_be = 4'b0001;
    #1;
    chk("t3_match_ready", 64'(st_ready), 1);
    tick();
    st_valid = 1'b0;
    #1;
    chk("t3_count_after_merge", 64'(count), 8);
    st_valid = 1'b1; st_addr = 32'h2000; st_data = 32'h77; st_be = 4'hF;
    mem_ready = 1'b1;
    #1;
    chk("t3_stall_ready", 64'(st_ready), 0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("t3_count_after_pop", 64'(count), 7);
    chk("t3_ready_after_pop", 64'(st_ready), 1);
    tick();
    st_valid = 1'b0;
    #1;
    chk("t3_count_refill", 64'(count), 8);
    probe(32'h101C, 4'hF);
    chk("t3_merged_data", 64'(lookup_data), 32'hA00000EE);
    probe(32'h2000, 4'hF);
    chk("t3_late_hit", 64'(lookup_hit), 1);
    chk("t3_late_data", 64'(lookup_data), 32'h77);
    lookup_valid = 1'b0;
    drain(8);
    chk("t3_empty", 64'(empty), 1);

    // 4: youngest-wins forwarding, misses and partial hits
    store(32'h300, 32'h11223344, 4'hF);
    store(32'h500, 32'h55555555, 4'hF);
    store(32'h300, 32'h000000FF, 4'b0001);
    #1;
    chk("t4_count", 64'(count), 3);
    probe(32'h300, 4'hF);
    chk("t4_hit", 64'(lookup_hit), 1);
    chk("t4_partial", 64'(lookup_partial), 0);
    chk("t4_data", 64'(lookup_data), 32'h112233FF);
    probe(32'h304, 4'hF);
    chk("t4_miss_hit", 64'(lookup_hit), 0);
    chk("t4_miss_partial", 64'(lookup_partial), 0);
    chk("t4_miss_data", 64'(lookup_data), 0);
    probe(32'h300, 4'h0);
    chk("t4_zero_be_hit", 64'(lookup_hit), 0);
    lookup_valid = 1'b0;
    drain(3);
    store(32'h400, 32'h0000BEEF, 4'b0011);
    probe(32'h400, 4'hF);
    chk("t4_part_hit", 64'(lookup_hit), 0);
    chk("t4_part_partial", 64'(lookup_partial), 1);
    chk("t4_part_be_out", 64'(lookup_be_out), 4'b0011);
    chk("t4_part_data", 64'(lookup_data), 32'h0000BEEF);
    lookup_valid = 1'b0;
    #1;
    chk("t4_idle_hit", 64'(lookup_hit), 0);
    chk("t4_idle_data", 64'(lookup_data), 0);
    chk("t4_idle_be_out", 64'(lookup_be_out), 0);
    drain(1);
    chk("t4_empty", 64'(empty), 1);

    // 5: flush blocks stores while the buffer drains
    store(32'h600, 32'h1, 4'hF);
    store(32'h604, 32'h2, 4'hF);
    store(32'h608, 32'h3, 4'hF);
    flush = 1'b1; mem_ready = 1'b1;
    st_valid = 1'b1; st_addr = 32'h700; st_data = 32'h99; st_be = 4'hF;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("t5_flush_ready", 64'(st_ready), 0);
      chk("t5_flush_empty", 64'(empty), 0);
      tick();
    end
    chk("t5_empty_cycle4", 64'(empty), 1);
    chk("t5_still_blocked", 64'(st_ready), 0);
    flush = 1'b0; mem_ready = 1'b0;
    #1;
    chk("t5_ready_after", 64'(st_ready), 1);
    tick();
    st_valid = 1'b0;
    #1;
    chk("t5_count", 64'(count), 1);
    chk("t5_mem_addr", 64'(mem_addr), 32'h700);
    drain(1);

    // 6: reset mid-drain discards everything
    for (int i = 0; i < 5; i++) store(32'h800 + 32'(4 * i), 32'hB0 + 32'(i), 4'hF);
    mem_ready = 1'b1;
    tick();
    chk("t6_count_pre", 64'(count), 4);
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    chk("t6_mem_valid", 64'(mem_valid), 0);
    chk("t6_count", 64'(count), 0);
    chk("t6_empty", 64'(empty), 1);
    probe(32'h80C, 4'hF);
    chk("t6_hit", 64'(lookup_hit), 0);
    chk("t6_partial", 64'(lookup_partial), 0);
    lookup_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
